dual_port_ram_be: RTL and testbench
===================================

Name: dual_port_ram_be

Overview:
- Parametrised true dual-port synchronous RAM. Successor to the fixed 8x64 dual-port RAM.
- Two independent read/write ports on one clock.
- Adds configurable data width and depth, per-byte write enables, port enables with read-valid strobes, and a post-reset zero-fill sequencer.
- Adds write-write and read-write collision detection.
- Used as the generic shared buffer between producer and consumer datapaths.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; must be a power of two, minimum 4.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- BE_W, DATA_W/8, byte-enable width; derived.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_a  in  1  port A access request.
- we_a  in  1  port A write (qualified by en_a).
- be_a  in  BE_W  port A byte enables (qualified by we_a).
- addr_a  in  ADDR_W  port A address.
- data_a  in  DATA_W  port A write data.
- q_a  out  DATA_W  port A read data.
- valid_a  out  1  q_a holds the result of an accepted access.
- en_b, we_b, be_b, addr_b, data_b, q_b, valid_b: identical set for port B.
- busy  out  1  zero-fill in progress; all port requests are ignored.
- coll  out  1  one-cycle pulse when a collision is detected this access.

Behaviour:
- Reset (rst_n low, async):
  - q_a, q_b, valid_a, valid_b and coll go to 0.
  - busy goes to 1 and the fill counter goes to 0.
  - Memory contents are not reset directly.
- FSM states:
  - FILL: entered from reset. Writes all-zero to address cnt each cycle, then cnt+1. After writing DEPTH-1, goes to RUN. busy stays 1 for exactly DEPTH cycles after rst_n rises.
  - RUN: normal operation; busy = 0. Remains here until the next reset.
  - rst_n asserted mid-FILL or mid-RUN returns to FILL with cnt = 0; the fill restarts from address 0.
- Requests while busy=1 are dropped: no write, no valid.
- Access acceptance (RUN, en_x = 1), result at the next edge:
  - valid_x = 1 exactly one cycle after acceptance; read latency is 1.
  - valid_x = 0 the cycle after a non-accepted access.
  - q_x is not updated while valid_x = 0 and holds its last value.
- Writes (we_x = 1):
  - For each byte i with be_x[i] = 1: ram[addr][8i+7:8i] <= data_x byte i. Bytes with be = 0 are preserved.
  - Same-port read-during-write is write-first: q_x = the merged word (new bytes where be = 1, old bytes elsewhere).
  - be_x = 0 with we_x = 1 is a read that returns the old word. It does not count as a write for collisions.
- Reads (we_x = 0): q_x = ram[addr_x].
- Cross-port, same address, same cycle, both accepted:
  - Write/write: byte-wise, port A wins on bytes where both be = 1; port B's other enabled bytes are written. Each port's q returns its own merged view; port A's view is authoritative. coll = 1.
  - Write on one port, read on the other: the reader gets the OLD word (read-first across ports). coll = 1.
  - Read/read: no collision, coll = 0.
- coll asserts the cycle after the colliding accesses, aligned with the valid strobes.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range condition exists.

Optional Feature:
- Macro DPRAM_OUT_REG_EN.
- Defined: an extra output register stage on q_a, q_b, valid_a, valid_b and coll. Read latency becomes 2; the same reset values apply.
- Undefined: latency 1 as specified above.
- Collision, byte-enable and fill semantics are unchanged either way.

Decomposition:
- Package dpram_pkg holds:
  - FSM state typedef {ST_FILL, ST_RUN}.
  - Constant BYTE_W = 8.
  - Function for byte-merge of old/new words under an enable mask.
- One sub-module, dpram_fill_ctrl, holds the FSM, fill counter and busy. It drives fill write address/enable into the port-A write mux.
- The storage array and both port datapaths stay in the top module.

Test Plan (DATA_W = 16, DEPTH = 64):
- Release rst_n -> busy = 1 for exactly 64 cycles, then 0. A subsequent read of addr 0x3F on A returns 0x0000 with valid_a = 1 one cycle later.
- A writes 0xBEEF to addr 5 with be = 2'b11; next cycle B reads addr 5 -> q_b = 0xBEEF, valid_b = 1, coll = 0.
- A writes 0x12xx to addr 5 with be = 2'b10 and data 0x1234 -> ram[5] = 0x12EF. q_a shows 0x12EF the same access (write-first).
- Same cycle: A writes 0xAAAA and B writes 0x5555, both to addr 9, be = 11 -> ram[9] = 0xAAAA, coll pulses 1 for one cycle.
- A writes 0x7777 to addr 3 (old 0x0000) while B reads addr 3 -> q_b = 0x0000, coll = 1. A following B read gives 0x7777.
- Assert rst_n low at fill cycle 20 -> outputs clear immediately. After release, busy lasts a full 64 cycles and addresses 0-63 all read 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised byte-enable dual-port RAM.
package dpram_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int BYTE_W     = 8;
  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_fill_ctrl.sv
// Post-reset zero-fill sequencer: walks every address once, then releases busy.
//   state   | meaning
//   ST_FILL | writing zero to fill_addr each cycle, busy = 1
//   ST_RUN  | normal port operation, busy = 0, held until next reset
module dpram_fill_ctrl
  import dpram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy_o,
  output logic              fill_we_o,
  output logic [ADDR_W-1:0] fill_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = (state_q == ST_FILL);
  assign fill_we_o   = (state_q == ST_FILL);
  assign fill_addr_o = cnt_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, zero-fill after reset and collision flag.
// Define DPRAM_OUT_REG_EN to add an output register stage (read latency 2).
module dual_port_ram_be
  import dpram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [BE_W-1:0]   be_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              valid_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [BE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              valid_b,
  output logic              busy,
  output logic              coll
);

  if (DATA_W % BYTE_W != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
    $error("dual_port_ram_be: DATA_W must be a multiple of 8 and <= MAX_DATA_W");
  end
  if (DEPTH < 4 || (1 << ADDR_W) != DEPTH) begin : g_bad_depth
    $error("dual_port_ram_be: DEPTH must be a power of two, at least 4");
  end

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(byte_merge(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w), MAX_BE_W'(be)));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy_w, fill_we;
  logic [ADDR_W-1:0] fill_addr;

  dpram_fill_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fill_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy_o      (busy_w),
    .fill_we_o   (fill_we),
    .fill_addr_o (fill_addr)
  );

  assign busy = busy_w;

  logic              acc_a, acc_b, wr_a, wr_b;
  logic [BE_W-1:0]   be_eff_a, be_eff_b;
  logic [DATA_W-1:0] old_a, old_b, view_a, view_b, wdata_a;
  logic              same_addr, both_acc, ww_same, coll_d;

  assign acc_a    = en_a & ~busy_w;
  assign acc_b    = en_b & ~busy_w;
  // An all-zero byte mask turns a write into a plain read.
  assign wr_a     = acc_a & we_a & (|be_a);
  assign wr_b     = acc_b & we_b & (|be_b);
  assign be_eff_a = we_a ? be_a : '0;
  assign be_eff_b = we_b ? be_b : '0;

  assign old_a  = mem_q[addr_a];
  assign old_b  = mem_q[addr_b];
  assign view_a = merge_w(old_a, data_a, be_eff_a);
  assign view_b = merge_w(old_b, data_b, be_eff_b);

  assign same_addr = (addr_a == addr_b);
  assign both_acc  = acc_a & acc_b & same_addr;
  assign ww_same   = both_acc & wr_a & wr_b;
  assign coll_d    = both_acc & (wr_a | wr_b);

  // Same-address double write folds into one port-A write: B's bytes first, A's on top.
  assign wdata_a = ww_same ? merge_w(view_b, data_a, be_a) : view_a;

  logic              mem_we_a, mem_we_b;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_wdata_a;

  assign mem_we_a    = busy_w ? fill_we   : wr_a;
  assign mem_addr_a  = busy_w ? fill_addr : addr_a;
  assign mem_wdata_a = busy_w ? '0        : wdata_a;
  assign mem_we_b    = wr_b & ~ww_same;

  always_ff @(posedge clk) begin
    if (mem_we_b) mem_q[addr_b] <= view_b;
    if (mem_we_a) mem_q[mem_addr_a] <= mem_wdata_a;
  end

  logic [DATA_W-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
  logic              valid_a_q, valid_b_q, coll_q;

  always_comb begin
    q_a_d = q_a_q;
    q_b_d = q_b_q;
    if (acc_a) q_a_d = view_a;
    if (acc_b) q_b_d = view_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q     <= '0;
      q_b_q     <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      q_a_q     <= q_a_d;
      q_b_q     <= q_b_d;
      valid_a_q <= acc_a;
      valid_b_q <= acc_b;
      coll_q    <= coll_d;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_W-1:0] q_a_o_q, q_b_o_q;
  logic              valid_a_o_q, valid_b_o_q, coll_o_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_o_q     <= '0;
      q_b_o_q     <= '0;
      valid_a_o_q <= 1'b0;
      valid_b_o_q <= 1'b0;
      coll_o_q    <= 1'b0;
    end else begin
      if (valid_a_q) q_a_o_q <= q_a_q;
      if (valid_b_q) q_b_o_q <= q_b_q;
      valid_a_o_q <= valid_a_q;
      valid_b_o_q <= valid_b_q;
      coll_o_q    <= coll_q;
    end
  end

  assign q_a     = q_a_o_q;
  assign q_b     = q_b_o_q;
  assign valid_a = valid_a_o_q;
  assign valid_b = valid_b_o_q;
  assign coll    = coll_o_q;
`else
  assign q_a     = q_a_q;
  assign q_b     = q_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;
  assign coll    = coll_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench for dual_port_ram_be: reference memory model, randomized and directed traffic.
module tb_dual_port_ram_be;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [BE_W-1:0]   be_a = '0, be_b = '0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] data_a = '0, data_b = '0;
  logic [DATA_W-1:0] q_a, q_b;
  logic              valid_a, valid_b, busy, coll;

  always #5 clk = ~clk;

  dual_port_ram_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
    .q_a(q_a), .valid_a(valid_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
    .q_b(q_b), .valid_b(valid_b),
    .busy(busy), .coll(coll)
  );

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_a_q[$], exp_b_q[$];
  bit                exp_coll_q[$];
  logic [DATA_W-1:0] hold_a = '0, hold_b = '0;
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] merge16(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0]  = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_a = '0;
      hold_b = '0;
    end else begin
      if (valid_a === 1'b1) begin
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid_a_unexpected: got q_a %h expected no result", q_a);
        end else begin
          hold_a = exp_a_q.pop_front();
          check16("q_a", q_a, hold_a);
        end
      end else check16("q_a_hold", q_a, hold_a);
      if (valid_b === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid_b_unexpected: got q_b %h expected no result", q_b);
        end else begin
          hold_b = exp_b_q.pop_front();
          check16("q_b", q_b, hold_b);
        end
      end else check16("q_b_hold", q_b, hold_b);
      if (valid_a === 1'b1 || valid_b === 1'b1) begin
        if (exp_coll_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL coll_queue_empty: got coll %b expected an entry", coll);
        end else check1("coll", coll, exp_coll_q.pop_front());
      end else check1("coll_idle", coll, 1'b0);
    end
  end

  // Called at posedge+1; the access is accepted at the following edge.
  task automatic issue(input bit ea, input bit wa, input logic [1:0] ba, input logic [5:0] aa,
                       input logic [15:0] da, input bit eb, input bit wb, input logic [1:0] bb,
                       input logic [5:0] ab, input logic [15:0] db);
    logic [15:0] va, vb;
    bit wra, wrb;
    va  = merge16(model_mem[aa], da, wa ? ba : 2'b00);
    vb  = merge16(model_mem[ab], db, wb ? bb : 2'b00);
    wra = ea && wa && (ba != 2'b00);
    wrb = eb && wb && (bb != 2'b00);
    if (ea) exp_a_q.push_back(va);
    if (eb) exp_b_q.push_back(vb);
    if (ea || eb) exp_coll_q.push_back(ea && eb && (aa == ab) && (wra || wrb));
    if (wrb) model_mem[ab] = vb;
    if (wra) model_mem[aa] = merge16(model_mem[aa], da, ba);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = db;
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a_q.size() + exp_b_q.size() + exp_coll_q.size()) != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ((exp_a_q.size() + exp_b_q.size() + exp_coll_q.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending expected 0", exp_a_q.size(),
               exp_b_q.size(), exp_coll_q.size());
    end
  endtask

  // Releases reset while hammering both ports; requests must be dropped during the fill.
  task automatic release_and_fill();
    int n = 0;
    rst_n = 1'b1;
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 6'd5; data_a = 16'hFFFF;
    en_b = 1'b1; we_b = 1'b1; be_b = 2'b11; addr_b = 6'd6; data_b = 16'hEEEE;
    forever begin
      @(negedge clk);
      if (busy !== 1'b1 || n >= 200) break;
      n++;
    end
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    check16("busy_cycles", 16'(n), 16'd64);
    @(posedge clk); #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    check16("rst_q_a", q_a, 16'h0000);
    check16("rst_q_b", q_b, 16'h0000);
    check1("rst_valid_a", valid_a, 1'b0);
    check1("rst_valid_b", valid_b, 1'b0);
    check1("rst_coll", coll, 1'b0);
    check1("rst_busy", busy, 1'b1);
    exp_a_q.delete(); exp_b_q.delete(); exp_coll_q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, 1'b0, 2'b00, 6'(i), 16'h0, 1'b1, 1'b0, 2'b00, 6'(DEPTH - 1 - i), 16'h0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ba, bb;
    logic [5:0] aa, ab;
    bit ea, eb, wa, wb;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    assert_reset();
    @(posedge clk); #1;
    release_and_fill();

    // Directed sequence from the plan
    issue(1, 0, 2'b00, 6'h3F, 16'h0, 0, 0, 2'b00, 6'h0, 16'h0);
    issue(1, 1, 2'b11, 6'd5, 16'hBEEF, 0, 0, 2'b00, 6'h0, 16'h0);
    issue(0, 0, 2'b00, 6'd0, 16'h0, 1, 0, 2'b00, 6'd5, 16'h0);
    issue(1, 1, 2'b10, 6'd5, 16'h1234, 0, 0, 2'b00, 6'h0, 16'h0);
    issue(1, 0, 2'b00, 6'd5, 16'h0, 0, 0, 2'b00, 6'h0, 16'h0);
    issue(1, 1, 2'b11, 6'd9, 16'hAAAA, 1, 1, 2'b11, 6'd9, 16'h5555);
    issue(1, 0, 2'b00, 6'd9, 16'h0, 1, 0, 2'b00, 6'd9, 16'h0);
    issue(1, 1, 2'b11, 6'd3, 16'h7777, 1, 0, 2'b00, 6'd3, 16'h0);
    issue(0, 0, 2'b00, 6'd0, 16'h0, 1, 0, 2'b00, 6'd3, 16'h0);
    // Byte-level write/write: A owns the low byte, B supplies the high byte
    issue(1, 1, 2'b11, 6'd12, 16'h5511, 0, 0, 2'b00, 6'h0, 16'h0);
    issue(1, 1, 2'b01, 6'd12, 16'h00AA, 1, 1, 2'b11, 6'd12, 16'h5566);
    issue(0, 0, 2'b00, 6'd0, 16'h0, 1, 0, 2'b00, 6'd12, 16'h0);
    // be = 0 write is a read and does not collide with a read
    issue(1, 1, 2'b00, 6'd12, 16'hFFFF, 1, 0, 2'b00, 6'd12, 16'h0);
    drain();

    for (int k = 0; k < 400; k++) begin
      ea = 1'($urandom_range(0, 1)); eb = 1'($urandom_range(0, 1));
      wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      ba = 2'($urandom_range(0, 3)); bb = 2'($urandom_range(0, 3));
      aa = 6'($urandom_range(0, 7)); ab = 6'($urandom_range(0, 7));
      if (ea && eb && wa && wb && aa == ab && ba != 0 && bb != 0) ba = 2'b11;
      issue(ea, wa, ba, aa, 16'($urandom), eb, wb, bb, ab, 16'($urandom));
    end
    drain();
    sweep();

    // Reset clears live outputs, then a fill interrupted at cycle 20 restarts from scratch
    assert_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check1("midfill_busy", busy, 1'b1);
    assert_reset();
    @(posedge clk); #1;
    release_and_fill();
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
